gpu_mem_arbiter: RTL and testbench

GPU_MEM_ARBITER -- requirements
Module: gpu_mem_arbiter

---
 rtl/gpu_mem_arbiter_pkg.sv | 8 +
 rtl/gpu_mem_arbiter_rr_select.sv | 22 ++
 rtl/gpu_mem_arbiter.sv | 99 +++++++++
 tb/tb_gpu_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_arbiter_pkg.sv
// gpu_mem_arbiter_pkg: shared arbiter state encoding and data-memory timing
package gpu_mem_arbiter_pkg;
  typedef enum logic {OPEN, LOCKED} arb_state_t;
  localparam int MEM_RD_LAT = 1;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gpu_mem_arbiter_rr_select.sv
// rr_select: rotating-priority pick of the first valid requester at or above ptr
module rr_select #(
  parameter int N = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  // Scanning from the far end lets the nearest valid requester overwrite earlier hits
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid[(int'(ptr) + i) % N]) begin
        gnt = N'(1) << ((int'(ptr) + i) % N);
        idx = IW'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/gpu_mem_arbiter.sv
// gpu_mem_arbiter: round-robin beat arbiter with burst locking in front of a single-port data BRAM
module gpu_mem_arbiter
  import gpu_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = 16,
  parameter int MAX_BURST = 16,
  localparam int IDX_W = idx_w(NUM_REQ)
) (
  input  logic                      gpu_clk,
  input  logic                      gpu_aresetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*4-1:0]      req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      mem_en,
  output logic [3:0]                mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      locked
);
  arb_state_t state, state_nx;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nx, owner, owner_nx, sel_idx, win, win_inc;
  logic [7:0] beat_cnt, beat_cnt_nx, beat_inc;
  logic [NUM_REQ-1:0] sel_gnt;
  logic [NUM_REQ-1:0] resp_pipe [MEM_RD_LAT];
  logic [3:0] win_we;
  logic run, acc, win_lock, release_lock;

  rr_select #(.N(NUM_REQ), .IW(IDX_W)) u_sel (
    .valid(req_valid),
    .ptr(rr_ptr),
    .gnt(sel_gnt),
    .idx(sel_idx)
  );

  always_comb begin
    win = state == LOCKED ? owner : sel_idx;
    win_inc = win == IDX_W'(NUM_REQ - 1) ? '0 : win + 1'b1;
    win_we = req_we[win*4 +: 4];
    win_lock = req_lock[win];
    req_ready = !run ? '0 : state == OPEN ? sel_gnt : req_valid[owner] ? NUM_REQ'(1) << owner : '0;
    acc = |req_ready;
    beat_inc = beat_cnt + 8'd1;
    // Owner lets go on an unlocked beat, on going idle unlocked, or when the burst cap is hit
    release_lock = acc ? (!win_lock || beat_inc == 8'(MAX_BURST)) : (!req_valid[owner] && !req_lock[owner]);
    mem_en = acc;
    mem_we = acc ? win_we : '0;
    mem_addr = acc ? req_addr[win*ADDR_W +: ADDR_W] : '0;
    mem_wdata = acc ? req_wdata[win*32 +: 32] : '0;
    state_nx = state;
    rr_ptr_nx = rr_ptr;
    owner_nx = owner;
    beat_cnt_nx = beat_cnt;
    if (state == OPEN) begin
      if (acc && win_lock && MAX_BURST > 1) begin
        state_nx = LOCKED;
        owner_nx = win;
        beat_cnt_nx = 8'd1;
      end else if (acc) rr_ptr_nx = win_inc;
    end else if (release_lock) begin
      state_nx = OPEN;
      rr_ptr_nx = win_inc;
      beat_cnt_nx = '0;
    end else if (acc) beat_cnt_nx = beat_inc;
  end

  // run gates grants so reset release is taken up on a clock edge, not mid-cycle
  always_ff @(posedge gpu_clk or negedge gpu_aresetn) begin
    if (!gpu_aresetn) begin
      state <= OPEN;
      rr_ptr <= '0;
      owner <= '0;
      beat_cnt <= '0;
      grant_id <= '0;
      run <= 1'b0;
      for (int i = 0; i < MEM_RD_LAT; i++) resp_pipe[i] <= '0;
    end else begin
      state <= state_nx;
      rr_ptr <= rr_ptr_nx;
      owner <= owner_nx;
      beat_cnt <= beat_cnt_nx;
      run <= 1'b1;
      if (acc) grant_id <= win;
      resp_pipe[0] <= (acc && win_we == 4'h0) ? req_ready : '0;
      for (int i = 1; i < MEM_RD_LAT; i++) resp_pipe[i] <= resp_pipe[i-1];
    end
  end

  assign resp_valid = resp_pipe[MEM_RD_LAT-1];
  assign resp_rdata = |resp_valid ? mem_rdata : '0;
  assign locked = state == LOCKED;
endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// tb_gpu_mem_arbiter: directed scenarios with a grant/response scoreboard plus a random fairness run
module tb_gpu_mem_arbiter;
  localparam int NR = 3, AW = 16, MB = 16, BOUND = (NR - 1) * MB;
  typedef struct packed {logic lock; logic [3:0] we; logic [AW-1:0] addr; logic [31:0] wdata;} beat_t;
  typedef struct packed {logic [1:0] id; logic [3:0] we; logic [AW-1:0] addr; logic [31:0] wdata;} gexp_t;
  typedef struct packed {logic [1:0] id; logic [31:0] data;} rexp_t;

  logic gpu_clk = 1'b0, gpu_aresetn = 1'b0;
  logic [NR-1:0] req_valid, req_ready, req_lock, resp_valid;
  logic [NR*4-1:0] req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*32-1:0] req_wdata;
  logic [31:0] resp_rdata, mem_rdata, mem_wdata;
  logic mem_en, locked;
  logic [3:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0] grant_id;

  beat_t rq[NR][$];
  gexp_t eg[$];
  rexp_t er[$];
  logic [NR-1:0] lock_idle = '0, hit = '0, rd_mask = '0;
  logic sb_on = 1'b1, rnd_on = 1'b0, had_gnt = 1'b0;
  logic [31:0] mem [0:255];
  int checks = 0, failures = 0, last_idx = 0;
  int wait_cnt[NR];
  int gcount[NR];

  gpu_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .MAX_BURST(MB)) dut (
    .gpu_clk(gpu_clk), .gpu_aresetn(gpu_aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_id(grant_id), .locked(locked)
  );

  always #5 gpu_clk = ~gpu_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic beat(input int r, input logic lk, input logic [3:0] we, input logic [AW-1:0] a, input logic [31:0] d);
    rq[r].push_back({lk, we, a, d});
  endtask

  task automatic expg(input int r, input logic [3:0] we, input logic [AW-1:0] a, input logic [31:0] d);
    eg.push_back({2'(r), we, a, d});
  endtask

  task automatic expr(input int r, input logic [31:0] d);
    er.push_back({2'(r), d});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((eg.size() + er.size()) != 0 && n < 400) begin
      @(negedge gpu_clk);
      n++;
    end
    repeat (2) @(negedge gpu_clk);
    chk(name, 32'(eg.size() + er.size()), 0);
  endtask

  task automatic wait_until(input string name, input int sel);
    int n = 0;
    while (!(sel == 0 ? locked : req_ready[2]) && n < 100) begin
      @(negedge gpu_clk);
      n++;
    end
    chk(name, 32'(n < 100), 1);
  endtask

  // BRAM model: byte-strobed writes, one-cycle read latency
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
    forever begin
      @(posedge gpu_clk);
      if (mem_en) begin
        for (int b = 0; b < 4; b++) if (mem_we[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        mem_rdata <= mem[mem_addr[7:0]];
      end
    end
  end

  // Requester driver: hold the head beat until it is accepted
  initial begin
    req_valid = '0; req_lock = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    forever begin
      @(posedge gpu_clk);
      #1;
      for (int r = 0; r < NR; r++) begin
        if (hit[r] && rq[r].size() > 0) void'(rq[r].pop_front());
        if (rnd_on) begin
          req_valid[r] = 1'b1;
          req_lock[r] = $urandom_range(0, 7) != 0;
          req_we[r*4 +: 4] = $urandom_range(0, 1) != 0 ? 4'hF : 4'h0;
          req_addr[r*AW +: AW] = AW'($urandom_range(0, 255));
          req_wdata[r*32 +: 32] = $urandom;
        end else if (rq[r].size() > 0) begin
          req_valid[r] = 1'b1;
          req_lock[r] = rq[r][0].lock;
          req_we[r*4 +: 4] = rq[r][0].we;
          req_addr[r*AW +: AW] = rq[r][0].addr;
          req_wdata[r*32 +: 32] = rq[r][0].wdata;
        end else begin
          req_valid[r] = 1'b0;
          req_lock[r] = lock_idle[r];
          req_we[r*4 +: 4] = '0;
          req_addr[r*AW +: AW] = '0;
          req_wdata[r*32 +: 32] = '0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every grant and every response
  initial begin
    gexp_t g;
    rexp_t e;
    int gi;
    for (int r = 0; r < NR; r++) begin wait_cnt[r] = 0; gcount[r] = 0; end
    forever begin
      @(negedge gpu_clk);
      hit = req_ready;
      gi = -1;
      for (int r = 0; r < NR; r++) if (req_ready[r]) gi = r;
      if (sb_on && had_gnt) chk("grant_id", 32'(grant_id), 32'(last_idx));
      if (gi >= 0) begin
        chk("ready_onehot", 32'($onehot(req_ready)), 1);
        if (rnd_on) begin
          chk("wait_bound", 32'(wait_cnt[gi] <= BOUND), 1);
          gcount[gi]++;
        end
        if (sb_on) begin
          if (eg.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_grant: got requester %0d expected none", gi);
          end else begin
            g = eg.pop_front();
            chk("grant_req", 32'(gi), 32'(g.id));
            chk("mem_en", 32'(mem_en), 1);
            chk("mem_we", 32'(mem_we), 32'(g.we));
            chk("mem_addr", 32'(mem_addr), 32'(g.addr));
            chk("mem_wdata", mem_wdata, g.wdata);
          end
        end
      end else if (sb_on) begin
        chk("mem_idle_en", 32'(mem_en), 0);
        chk("mem_idle_wdata", mem_wdata, 0);
      end
      if (sb_on && resp_valid != '0) begin
        chk("resp_timing", 32'(resp_valid), 32'(rd_mask));
        if (er.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp: got resp_valid %b expected none", resp_valid);
        end else begin
          e = er.pop_front();
          chk("resp_req", 32'(resp_valid), 32'(1) << e.id);
          chk("resp_rdata", resp_rdata, e.data);
        end
      end
      had_gnt = gi >= 0;
      last_idx = gi;
      rd_mask = (gi >= 0 && req_we[(gi < 0 ? 0 : gi)*4 +: 4] == 4'h0) ? req_ready : '0;
      for (int r = 0; r < NR; r++) wait_cnt[r] = (rnd_on && req_valid[r] && !req_ready[r]) ? wait_cnt[r] + 1 : 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // All three read from reset: grants 0,1,2 back to back
    for (int r = 0; r < NR; r++) begin
      beat(r, 1'b0, 4'h0, AW'(r + 1), 32'h0);
      expg(r, 4'h0, AW'(r + 1), 32'h0);
      expr(r, 32'hA000_0000 | 32'(r + 1));
    end
    repeat (3) @(negedge gpu_clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    gpu_aresetn = 1'b1;
    #1;
    chk("release_no_grant", 32'(req_ready), 0);
    @(negedge gpu_clk);
    chk("first_grant", 32'(req_ready), 32'b001);
    drain("t1_drain");

    // Write then read back through requester 1
    beat(1, 1'b0, 4'hF, 16'h0010, 32'hDEADBEEF);
    beat(1, 1'b0, 4'h0, 16'h0010, 32'h0);
    expg(1, 4'hF, 16'h0010, 32'hDEADBEEF);
    expg(1, 4'h0, 16'h0010, 32'h0);
    expr(1, 32'hDEADBEEF);
    drain("t2_drain");

    // 40-beat locked burst from 0 is cut at 16 beats so requester 2 gets in
    for (int i = 0; i < 40; i++) beat(0, i < 39, 4'h0, AW'(16'h40 + i), 32'h0);
    for (int i = 0; i < 40; i++) begin
      if (i == 16) begin
        expg(2, 4'h0, 16'h0080, 32'h0);
        expr(2, 32'hA000_0080);
      end
      expg(0, 4'h0, AW'(16'h40 + i), 32'h0);
      expr(0, 32'hA000_0040 + 32'(i));
    end
    wait_until("t3_locked", 0);
    beat(2, 1'b0, 4'h0, 16'h0080, 32'h0);
    wait_until("t3_req2_grant", 1);
    chk("t3_unlocked", 32'(locked), 0);
    drain("t3_drain");

    // Idle owner 1 keeps the lock; others are blocked until it lets go
    lock_idle[1] = 1'b1;
    beat(1, 1'b1, 4'h0, 16'h0005, 32'h0);
    expg(1, 4'h0, 16'h0005, 32'h0);
    expr(1, 32'hA000_0005);
    expg(2, 4'h0, 16'h0007, 32'h0);
    expr(2, 32'hA000_0007);
    expg(0, 4'h0, 16'h0006, 32'h0);
    expr(0, 32'hA000_0006);
    wait_until("t4_locked", 0);
    beat(0, 1'b0, 4'h0, 16'h0006, 32'h0);
    beat(2, 1'b0, 4'h0, 16'h0007, 32'h0);
    repeat (4) begin
      @(negedge gpu_clk);
      chk("t4_blocked", 32'(req_ready), 0);
      chk("t4_locked_hold", 32'(locked), 1);
    end
    lock_idle[1] = 1'b0;
    drain("t4_drain");

    // Asynchronous reset in the middle of a locked read burst
    sb_on = 1'b0;
    for (int i = 0; i < 10; i++) beat(0, 1'b1, 4'h0, AW'(16'h20 + i), 32'h0);
    @(negedge gpu_clk);
    wait_until("t5_locked", 0);
    @(posedge gpu_clk);
    #2;
    chk("t5_inflight", 32'(resp_valid), 32'b001);
    gpu_aresetn = 1'b0;
    #1;
    chk("t5_rst_resp", 32'(resp_valid), 0);
    chk("t5_rst_ready", 32'(req_ready), 0);
    chk("t5_rst_mem_en", 32'(mem_en), 0);
    chk("t5_rst_locked", 32'(locked), 0);
    chk("t5_rst_grant_id", 32'(grant_id), 0);
    for (int r = 0; r < NR; r++) rq[r].delete();
    eg.delete();
    er.delete();
    @(negedge gpu_clk);
    chk("t5_rst_resp_hold", 32'(resp_valid), 0);
    for (int r = 0; r < NR; r++) begin
      beat(r, 1'b0, 4'h0, AW'(16'h30 + r), 32'h0);
      expg(r, 4'h0, AW'(16'h30 + r), 32'h0);
      expr(r, 32'hA000_0030 + 32'(r));
    end
    sb_on = 1'b1;
    @(negedge gpu_clk);
    gpu_aresetn = 1'b1;
    @(negedge gpu_clk);
    chk("t5_first_grant", 32'(req_ready), 32'b001);
    drain("t5_drain");

    // Random locking traffic with everyone always requesting
    sb_on = 1'b0;
    rnd_on = 1'b1;
    repeat (10000) @(negedge gpu_clk);
    rnd_on = 1'b0;
    repeat (4) @(negedge gpu_clk);
    for (int r = 0; r < NR; r++) chk("rnd_served", 32'(gcount[r] > 0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
